// File: rtl/clock_div_pkg.sv
// ----------------------------------------------------------------------------
// clock_div_pkg : shared constants, state encoding and divisor clamp
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package clock_div_pkg;

  localparam int MIN_DIV = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Divisors below MIN_DIV cannot produce a high and a low phase
  function automatic logic [31:0] clamp_div(input logic [31:0] n);
    return (n < 32'(MIN_DIV)) ? 32'(MIN_DIV) : n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_div_chan.sv
// ----------------------------------------------------------------------------
// clock_div_chan : one reloadable divider channel with clean start/stop
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int DEFAULT_N = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [SIZE-1:0] DIV_N,
  input  logic            DIV_LOAD,
  input  logic            DIV_EN,
  output logic            CLK_OUT,
  output logic            TICK,
  output logic            PENDING
);

  logic [1:0]      state_q,   state_d;
  logic [SIZE-1:0] cnt_q,     cnt_d;
  logic [SIZE-1:0] cur_n_q,   cur_n_d;
  logic [SIZE-1:0] pend_n_q,  pend_n_d;
  logic            pending_q, pending_d;
  logic            clk_out_q, clk_out_d;
  logic            tick_q,    tick_d;

  logic            active;
  logic            wrap;
  logic [SIZE-1:0] clamp_n;

  assign active  = (state_q == RUN) || (state_q == DRAIN);
  assign wrap    = active && (cnt_q == cur_n_q - SIZE'(1));
  assign clamp_n = SIZE'(clamp_div(32'(DIV_N)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_n_d   = cur_n_q;
    pend_n_d  = pend_n_q;
    pending_d = pending_q;
    clk_out_d = active && (cnt_q < (cur_n_q >> 1));
    tick_d    = active && (cnt_q == '0);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (DIV_EN) state_d = RUN;
      end
      RUN: begin
        if (!DIV_EN) state_d = DRAIN;
      end
      DRAIN: begin
        // Re-enable wins over the wrap so a restart never leaves a gap
        if (DIV_EN)    state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (active) cnt_d = wrap ? '0 : cnt_q + SIZE'(1);

    // New divisors only take effect at a period boundary while running
    if (!active) begin
      if (DIV_LOAD) cur_n_d = clamp_n;
    end else if (wrap) begin
      if (DIV_LOAD) begin
        cur_n_d   = clamp_n;
        pending_d = 1'b0;
      end else if (pending_q) begin
        cur_n_d   = pend_n_q;
        pending_d = 1'b0;
      end
    end else if (DIV_LOAD) begin
      pend_n_d  = clamp_n;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_n_q   <= SIZE'(DEFAULT_N);
      pend_n_q  <= SIZE'(DEFAULT_N);
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_n_q   <= cur_n_d;
      pend_n_q  <= pend_n_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign CLK_OUT = clk_out_q;
  assign TICK    = tick_q;
  assign PENDING = pending_q;

endmodule

`default_nettype wire

// File: rtl/clock_div_bank.sv
// ----------------------------------------------------------------------------
// clock_div_bank : CHANNELS independent programmable clock dividers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module clock_div_bank
  import clock_div_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int SIZE      = 8,
  parameter int DEFAULT_N = 6
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [CHANNELS*SIZE-1:0] DIV_N,
  input  logic [CHANNELS-1:0]      DIV_LOAD,
  input  logic [CHANNELS-1:0]      DIV_EN,
  output logic [CHANNELS-1:0]      CLK_OUT,
  output logic [CHANNELS-1:0]      TICK,
  output logic [CHANNELS-1:0]      PENDING
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    clock_div_chan #(
      .SIZE      (SIZE),
      .DEFAULT_N (DEFAULT_N)
    ) u_chan (
      .CLK      (CLK),
      .RESET    (RESET),
      .DIV_N    (DIV_N[c*SIZE +: SIZE]),
      .DIV_LOAD (DIV_LOAD[c]),
      .DIV_EN   (DIV_EN[c]),
      .CLK_OUT  (CLK_OUT[c]),
      .TICK     (TICK[c]),
      .PENDING  (PENDING[c])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clock_div_bank.sv
// ----------------------------------------------------------------------------
// tb_clock_div_bank : directed and random stimulus against a period-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_clock_div_bank;

  localparam int CH = 2;
  localparam int SZ = 8;
  localparam int DN = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*SZ-1:0]  div_n;
  logic [CH-1:0]     div_load;
  logic [CH-1:0]     div_en;
  logic [CH-1:0]     clk_out;
  logic [CH-1:0]     tick;
  logic [CH-1:0]     pending;

  always #5 clk = ~clk;

  clock_div_bank #(
    .CHANNELS  (CH),
    .SIZE      (SZ),
    .DEFAULT_N (DN)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .DIV_N    (div_n),
    .DIV_LOAD (div_load),
    .DIV_EN   (div_en),
    .CLK_OUT  (clk_out),
    .TICK     (tick),
    .PENDING  (pending)
  );

  int total = 0;
  int bad   = 0;

  // Reference: position within the period, period length, queued length
  bit            m_on    [CH];
  bit            m_stop  [CH];
  int            m_pos   [CH];
  int            m_n     [CH];
  int            m_pend  [CH];
  logic [CH-1:0] m_clk;
  logic [CH-1:0] m_tick;
  logic [CH-1:0] m_pnd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_on[c] = 0; m_stop[c] = 0; m_pos[c] = 0; m_n[c] = DN; m_pend[c] = 0;
    end
    m_clk = '0; m_tick = '0; m_pnd = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      int  req;
      bit  en, ld, last;
      en  = div_en[c];
      ld  = div_load[c];
      req = int'(div_n[c*SZ +: SZ]);
      if (req < 2) req = 2;
      if (!m_on[c]) begin
        m_clk[c]  = 1'b0;
        m_tick[c] = 1'b0;
        if (ld) m_n[c] = req;
        if (en) begin m_on[c] = 1; m_pos[c] = 0; m_stop[c] = 0; end
      end else begin
        m_clk[c]  = (m_pos[c] < m_n[c] / 2);
        m_tick[c] = (m_pos[c] == 0);
        last = (m_pos[c] == m_n[c] - 1);
        if (last) begin
          if (ld)               begin m_n[c] = req;       m_pend[c] = 0; end
          else if (m_pend[c]>0) begin m_n[c] = m_pend[c]; m_pend[c] = 0; end
        end else if (ld) begin
          m_pend[c] = req;
        end
        m_pos[c] = last ? 0 : m_pos[c] + 1;
        if (m_stop[c] && last && !en) m_on[c] = 0;
        else                          m_stop[c] = !en;
      end
      m_pnd[c] = (m_pend[c] > 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    check("clk_out", 32'(clk_out), 32'(m_clk));
    check("tick",    32'(tick),    32'(m_tick));
    check("pending", 32'(pending), 32'(m_pnd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_n(input int c, input int v);
    div_n[c*SZ +: SZ] = SZ'(v);
  endtask

  task automatic load(input int c, input int v);
    set_n(c, v);
    div_load[c] = 1'b1;
    step();
    div_load[c] = 1'b0;
  endtask

  task automatic wait_pos(input int c, input int p);
    int g = 0;
    while (!(m_on[c] && m_pos[c] == p) && g < 100) begin step(); g++; end
    if (g >= 100) check("wait_pos_timeout", 32'(g), 32'(0));
  endtask

  // Observes one full high phase and the following low phase of channel c
  task automatic measure(input int c, input string tag, input int exp_hi, input int exp_lo);
    int g = 0, hi = 0, lo = 0;
    while (!clk_out[c] && g < 64) begin step(); g++; end
    if (g >= 64) check({tag, "_rise_timeout"}, 32'(g), 32'(0));
    while (clk_out[c] && hi < 64) begin step(); hi++; end
    while (!clk_out[c] && lo < 64) begin step(); lo++; end
    check({tag, "_high"}, 32'(hi), 32'(exp_hi));
    check({tag, "_low"},  32'(lo), 32'(exp_lo));
  endtask

  task automatic stop_all();
    div_en = '0;
    run(30);
  endtask

  initial begin
    rst = 1'b1; div_n = '0; div_load = '0; div_en = '0;
    model_reset();
    #1;
    check("reset_clk_out", 32'(clk_out), 32'(0));
    check("reset_tick",    32'(tick),    32'(0));
    check("reset_pending", 32'(pending), 32'(0));
    run(2);
    rst = 1'b0;
    run(2);

    // Start-up latency and default 3/3 pattern
    div_en[0] = 1'b1;
    step();
    check("rise_edge1", 32'(clk_out[0]), 32'(0));
    step();
    check("rise_edge2", 32'(clk_out[0]), 32'(1));
    check("rise_tick",  32'(tick[0]),    32'(1));
    run(4);
    measure(0, "n6", 3, 3);
    run(12);

    // Odd and clamped divisors loaded while idle
    stop_all();
    load(0, 5);  div_en[0] = 1'b1; measure(0, "n5", 2, 3); stop_all();
    load(0, 1);  div_en[0] = 1'b1; measure(0, "n1", 1, 1); stop_all();
    load(0, 0);  div_en[0] = 1'b1; measure(0, "n0", 1, 1); stop_all();

    // Mid-period reload, wrap-cycle reload, double reload
    load(0, 6);
    div_en[0] = 1'b1;
    run(8);
    wait_pos(0, 2);
    load(0, 4);
    check("pend_after_load", 32'(pending[0]), 32'(1));
    run(16);
    wait_pos(0, m_n[0] - 1);
    load(0, 9);
    check("pend_wrap_load", 32'(pending[0]), 32'(0));
    run(20);
    wait_pos(0, 2);
    load(0, 8);
    load(0, 10);
    run(30);

    // Stop during the high phase, then restart during drain
    stop_all();
    load(0, 6);
    div_en[0] = 1'b1;
    wait_pos(0, 1);
    div_en[0] = 1'b0;
    run(12);
    check("stopped_low", 32'(clk_out[0]), 32'(0));
    div_en[0] = 1'b1;
    wait_pos(0, 4);
    div_en[0] = 1'b0;
    run(2);
    div_en[0] = 1'b1;
    run(20);

    // Two channels with different divisors
    load(1, 3);
    div_en[1] = 1'b1;
    run(36);

    // Random enables and reloads on both channels
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 15) == 0) div_en[c] = ~div_en[c];
        div_load[c] = ($urandom_range(0, 9) == 0);
        if (div_load[c]) set_n(c, int'($urandom_range(0, 12)));
      end
      step();
    end
    div_load = '0;

    // Asynchronous reset in the middle of a high phase with a load pending
    stop_all();
    div_en = 2'b11;
    wait_pos(0, 1);
    load(0, 3);
    #2 rst = 1'b1;
    #1;
    check("async_clk_out", 32'(clk_out), 32'(0));
    check("async_tick",    32'(tick),    32'(0));
    check("async_pending", 32'(pending), 32'(0));
    model_reset();
    step();
    rst = 1'b0;
    measure(0, "post_reset", 3, 3);
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire

// File: doc/clock_div_bank.md
Name: clock_div_bank

Overview:
- Multi-channel programmable clock divider for the miner clock tree.
- Replaces the fixed single-divisor divider that derives SPI_CLK from M1_CLK.
- Generates CHANNELS independent divided clocks, plus aligned one-cycle tick pulses, from one source clock.
- Divisors are run-time reloadable, applied glitch-free at period boundaries; each channel can be started and stopped cleanly without runt pulses.

Parameters:
- CHANNELS, 2, number of independent divider channels.
- SIZE, 8, divisor/counter width in bits.
- DEFAULT_N, 6, divisor loaded into every channel at reset; must be >= 2.

Ports:
- CLK  input  1  source clock; all logic is on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- DIV_N  input  CHANNELS*SIZE  requested divisor per channel; channel c uses bits [c*SIZE +: SIZE].
- DIV_LOAD  input  CHANNELS  one-cycle strobe that captures DIV_N for channel c.
- DIV_EN  input  CHANNELS  level; channel c runs while high.
- CLK_OUT  output  CHANNELS  divided clock, registered.
- TICK  output  CHANNELS  one-cycle pulse, high in the first CLK cycle of each CLK_OUT high phase.
- PENDING  output  CHANNELS  high while a loaded divisor waits for a period boundary.

Behaviour:
- Reset state, per channel:
  - CLK_OUT=0, TICK=0, PENDING=0.
  - cnt=0, cur_n=DEFAULT_N, state=IDLE.
- Clamping: a captured DIV_N value of 0 or 1 is clamped to 2. Values never exceed 2^SIZE-1.
- Counting in RUN or DRAIN:
  - cnt <= (cnt==cur_n-1) ? 0 : cnt+1.
  - The wrap cycle is the cycle in which cnt==cur_n-1.
- Outputs are registered from the current cnt, so they lag cnt by one cycle:
  - CLK_OUT <= active && (cnt < cur_n>>1).
  - TICK <= active && (cnt==0).
  - active means state is RUN or DRAIN.
- Duty cycle: high for floor(N/2) cycles, low for ceil(N/2) cycles.
  - N=6 gives 3 high / 3 low.
  - N=5 gives 2 high / 3 low.
  - N=2 gives 1 high / 1 low.
- State machine, per channel:
  - IDLE: cnt held at 0, outputs 0. If DIV_EN=1, go to RUN, with cnt=0 in the first RUN cycle. CLK_OUT and TICK rise on the following edge (two edges after DIV_EN is sampled).
  - RUN: if DIV_EN=0, go to DRAIN and keep counting.
  - DRAIN: at the wrap cycle go to IDLE (cnt becomes 0, CLK_OUT stays 0). If DIV_EN returns to 1 before the wrap, go back to RUN with no phase disturbance.
  - No CLK_OUT high phase is ever shortened.
- Divisor update:
  - DIV_LOAD in IDLE: cur_n updates at the next edge and PENDING stays 0.
  - DIV_LOAD while active, not in the wrap cycle: the clamped value goes to pend_n and PENDING=1 from the next cycle.
  - At the wrap cycle with PENDING=1: cur_n <= pend_n and PENDING <= 0.
  - DIV_LOAD in the wrap cycle itself: the new value bypasses pend_n and becomes cur_n immediately for the next period; PENDING stays 0.
  - DIV_LOAD while PENDING=1: pend_n is overwritten; only the last value applies.
- Channels are fully independent and share no state except CLK and RESET.
- RESET asserted mid-period: all outputs go to 0 immediately (asynchronous) and pending loads are discarded.

Decomposition:
- Shared package clock_div_pkg:
  - MIN_DIV=2.
  - State encoding IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
  - The clamp function.
- One sub-module, clock_div_chan: a single channel with ports CLK, RESET, DIV_N[SIZE], DIV_LOAD, DIV_EN, CLK_OUT, TICK, PENDING.
- clock_div_bank is a generate loop of CHANNELS instances of clock_div_chan.

Test Plan:
- Reset then DIV_EN[0]=1 with DEFAULT_N=6:
  - CLK_OUT[0] first rises 2 edges after DIV_EN is sampled.
  - Steady 3 high / 3 low pattern thereafter.
  - TICK[0] pulses once per 6 cycles, coincident with each CLK_OUT rise.
- Odd and minimum divisors:
  - Load N=5 in IDLE and run: 2 high / 3 low.
  - Load N=1: clamped to 2, giving 1/1 toggling.
  - Load N=0: clamped to 2, giving 1/1 toggling.
- Reload mid-period:
  - Running N=6, load N=4 at cnt=2: PENDING=1 until the wrap, the current period completes as 6 cycles, the next period is 2 high / 2 low, and PENDING then clears.
  - Load at cnt==5 (the wrap cycle): no PENDING, and the next period uses the new N immediately.
  - Two loads (8 then 10) before the wrap: the period becomes 10.
- Stop and restart:
  - Drop DIV_EN at cnt=1 of N=6: the high phase completes fully, the low phase completes, then the channel goes IDLE with CLK_OUT=0.
  - Re-raise DIV_EN during DRAIN: the period continues with no gap.
- Independence and reset:
  - ch0 N=6 and ch1 N=3 running together: no cross-coupling.
  - Assert RESET asynchronously mid-high-phase: CLK_OUT=0, TICK=0 and PENDING=0 immediately, and cur_n returns to 6.
